// File: rtl/cpu_axil_master.sv
// Single-outstanding CPU request port to AXI4-Lite master bridge.
// Optional response timeout with DRAIN recovery when AXIL_MASTER_TIMEOUT_EN is defined.
module cpu_axil_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  input  logic [STRB_WIDTH-1:0] cpu_req_wstrb,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
  output logic                  cpu_rsp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(STRB_WIDTH) - ADDR_WIDTH'(1));

`ifdef AXIL_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DRAIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
`endif

  state_t state, next_state;

  logic                  run;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, timeout;
  logic                  unused_resp_bits;

  // Handshakes derived from state so the output decode never feeds back into itself.
  assign accept = cpu_req_valid & run & (state == IDLE);
  assign aw_hs  = (state == WR_ADDR_DATA) & ~aw_done & m_axil_awready;
  assign w_hs   = (state == WR_ADDR_DATA) & ~w_done & m_axil_wready;
  assign ar_hs  = (state == RD_ADDR) & m_axil_arready;
  assign b_hs   = (state == WR_RESP) & m_axil_bvalid;
  assign r_hs   = (state == RD_DATA) & m_axil_rvalid;

  assign unused_resp_bits = m_axil_bresp[0] ^ m_axil_rresp[0];

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting = (state == WR_RESP) | (state == RD_DATA);
  assign timeout = waiting & ~b_hs & ~r_hs & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wait_cnt <= '0;
    end else if (waiting && !b_hs && !r_hs && !timeout) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      run           <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      cpu_rsp_err   <= 1'b0;
    end else begin
      state         <= next_state;
      run           <= 1'b1;
      cpu_rsp_valid <= b_hs | r_hs | timeout;
      if (accept) begin
        addr_q  <= cpu_req_addr & ADDR_MASK;
        wdata_q <= cpu_req_wdata;
        wstrb_q <= cpu_req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (r_hs) begin
        cpu_rsp_rdata <= m_axil_rdata;
        cpu_rsp_err   <= m_axil_rresp[1];
      end else if (b_hs) begin
        cpu_rsp_rdata <= '0;
        cpu_rsp_err   <= m_axil_bresp[1];
      end else if (timeout) begin
        cpu_rsp_rdata <= '0;
        cpu_rsp_err   <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state     = state;
    cpu_req_ready  = 1'b0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_req_ready = run;
        if (accept) next_state = cpu_req_we ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        m_axil_awvalid = ~aw_done;
        m_axil_wvalid  = ~w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = WR_RESP;
      end
      WR_RESP: begin
        m_axil_bready = 1'b1;
        if (b_hs) next_state = IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (timeout) next_state = DRAIN;
`endif
      end
      RD_ADDR: begin
        m_axil_arvalid = 1'b1;
        if (ar_hs) next_state = RD_DATA;
      end
      RD_DATA: begin
        m_axil_rready = 1'b1;
        if (r_hs) next_state = IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (timeout) next_state = DRAIN;
`endif
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      DRAIN: begin
        m_axil_bready = 1'b1;
        m_axil_rready = 1'b1;
        if (m_axil_bvalid || m_axil_rvalid) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = '0;
  assign m_axil_arprot = '0;

endmodule
